// File: rtl/vproc_result_pkg.sv
// Shared types and field widths for the vector result arbiter.
package vproc_result_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CHAN,
        SRC_PEND,
        SRC_EMPTY
    } result_src_e;

    localparam int unsigned RES_RD_W      = 5;
    localparam int unsigned RES_DATA_W    = 32;
    localparam int unsigned RES_EXCCODE_W = 6;
    // Channel payload width excluding the ID: rd, we, data, exc, exccode
    localparam int unsigned RES_FIELDS_W  = RES_RD_W + 1 + RES_DATA_W + 1 + RES_EXCCODE_W;

    function automatic int unsigned result_chan_w(int unsigned id_w);
        return id_w + RES_FIELDS_W;
    endfunction

endpackage

// File: rtl/xif_result_if.sv
// XIF result interface between coprocessor and host.
interface xif_result_if #(
    parameter int unsigned X_ID_WIDTH = 3
);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
        logic [31:0]           data;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    logic      result_valid;
    logic      result_ready;
    x_result_t result;

    modport coproc_result (
        output result_valid,
        output result,
        input  result_ready
    );

    modport cpu_result (
        input  result_valid,
        input  result,
        output result_ready
    );

endinterface

// File: rtl/vproc_result_fifo.sv
// Fall-through FIFO: when empty, a pushed entry is presented at the head in the same cycle.
module vproc_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic async_rst_ni,
    input  logic push_i,
    input  T     data_i,
    output logic full_o,
    input  logic pop_i,
    output logic valid_o,
    output T     data_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             empty, wr_en, rd_en;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_FULL);
    assign valid_o = ~empty | push_i;
    assign data_o  = empty ? data_i : mem_q[rd_ptr_q];

    // A push into an empty FIFO that is popped in the same cycle bypasses storage
    assign wr_en = push_i & ~(empty & pop_i);
    assign rd_en = pop_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vproc_result_arb.sv
// Result arbiter: CHAN_CNT buffered result channels plus a pending empty-result set onto XIF.
// Define VPROC_RESULT_STATS_EN to build the per-source accepted-result counters.
module vproc_result_arb
    import vproc_result_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned CHAN_CNT       = 3,
    parameter int unsigned CHAN_BUF_DEPTH = 2,
    parameter arb_mode_e   ARB_MODE       = ARB_FIXED,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                                        clk_i,
    input  logic                                        async_rst_ni,
    input  logic                                        empty_valid_i,
    input  logic [XIF_ID_W-1:0]                         empty_id_i,
    input  logic [CHAN_CNT-1:0]                         chan_valid_i,
    output logic [CHAN_CNT-1:0]                         chan_ready_o,
    input  logic [CHAN_CNT-1:0][XIF_ID_W+RES_FIELDS_W-1:0] chan_res_i,
    output logic [CHAN_CNT:0][31:0]                     stat_cnt_o,
    xif_result_if.coproc_result                         xif_result
);

    localparam int unsigned ID_CNT     = 1 << XIF_ID_W;
    localparam int unsigned CHAN_IDX_W = (CHAN_CNT > 1) ? $clog2(CHAN_CNT) : 1;
    localparam logic [CHAN_IDX_W-1:0] CHAN_LAST = CHAN_IDX_W'(CHAN_CNT - 1);

    typedef struct packed {
        logic [XIF_ID_W-1:0]      id;
        logic [RES_RD_W-1:0]      rd;
        logic                     we;
        logic [RES_DATA_W-1:0]    data;
        logic                     exc;
        logic [RES_EXCCODE_W-1:0] exccode;
    } result_chan_t;

    result_chan_t [CHAN_CNT-1:0] head;
    logic [CHAN_CNT-1:0]         head_valid, full, pop;

    logic [CHAN_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_CNT-1:0]     pend_q, pend_d;
    logic                  hold_q;
    result_src_e           hold_src_q;
    logic [CHAN_IDX_W-1:0] hold_chan_q;
    logic [XIF_ID_W-1:0]   hold_id_q;

    logic [CHAN_IDX_W-1:0] arb_chan;
    logic                  arb_chan_valid;
    logic [XIF_ID_W-1:0]   pend_low;
    logic                  pend_any;
    result_src_e           sel_src;
    logic [CHAN_IDX_W-1:0] sel_chan;
    logic [XIF_ID_W-1:0]   sel_id;
    logic                  result_valid, accept;
    result_chan_t          res;

    for (genvar c = 0; c < CHAN_CNT; c++) begin : g_chan
        vproc_result_fifo #(
            .DEPTH (CHAN_BUF_DEPTH),
            .T     (result_chan_t)
        ) u_fifo (
            .clk_i        (clk_i),
            .async_rst_ni (async_rst_ni),
            .push_i       (chan_valid_i[c] & ~full[c]),
            .data_i       (result_chan_t'(chan_res_i[c])),
            .full_o       (full[c]),
            .pop_i        (pop[c]),
            .valid_o      (head_valid[c]),
            .data_o       (head[c])
        );
        assign pop[c] = accept & (sel_src == SRC_CHAN) & (sel_chan == CHAN_IDX_W'(c));
    end

    assign chan_ready_o = ~full;

    always_comb begin
        int unsigned idx;
        arb_chan_valid = 1'b0;
        arb_chan       = '0;
        idx            = 0;
        for (int unsigned k = 0; k < CHAN_CNT; k++) begin
            if (ARB_MODE == ARB_RR) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= CHAN_CNT) begin
                    idx = idx - CHAN_CNT;
                end
            end else begin
                idx = k;
            end
            if (!arb_chan_valid && head_valid[CHAN_IDX_W'(idx)]) begin
                arb_chan_valid = 1'b1;
                arb_chan       = CHAN_IDX_W'(idx);
            end
        end
    end

    always_comb begin
        pend_any = 1'b0;
        pend_low = '0;
        for (int unsigned i = 0; i < ID_CNT; i++) begin
            if (pend_q[i] && !pend_any) begin
                pend_any = 1'b1;
                pend_low = XIF_ID_W'(i);
            end
        end
    end

    // A held grant overrides arbitration so the presented result stays bit-stable
    always_comb begin
        sel_src  = SRC_NONE;
        sel_chan = arb_chan;
        sel_id   = pend_low;
        if (hold_q) begin
            sel_src  = hold_src_q;
            sel_chan = hold_chan_q;
            sel_id   = hold_id_q;
        end else if (arb_chan_valid) begin
            sel_src = SRC_CHAN;
        end else if (pend_any) begin
            sel_src = SRC_PEND;
        end else if (empty_valid_i) begin
            sel_src = SRC_EMPTY;
            sel_id  = empty_id_i;
        end
    end

    assign result_valid = (sel_src != SRC_NONE);
    assign accept       = result_valid & xif_result.result_ready;

    always_comb begin
        res = '0;
        if (!DONT_CARE_ZERO) begin
            res = 'x;
        end
        unique case (sel_src)
            SRC_CHAN: res = head[sel_chan];
            SRC_PEND, SRC_EMPTY: begin
                res    = '0;
                res.id = sel_id;
            end
            SRC_NONE: ;
        endcase
    end

    assign xif_result.result_valid = result_valid;
    assign xif_result.result       = {res.id, res.rd, res.we, res.data, res.exc, res.exccode};

    // Insert is applied after clear so a same-ID insert wins
    always_comb begin
        pend_d = pend_q;
        if (accept && sel_src == SRC_PEND) begin
            pend_d[sel_id] = 1'b0;
        end
        if (empty_valid_i && !(accept && sel_src == SRC_EMPTY)) begin
            pend_d[empty_id_i] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && sel_src == SRC_CHAN) begin
            rr_ptr_d = (sel_chan == CHAN_LAST) ? '0 : sel_chan + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            rr_ptr_q    <= '0;
            pend_q      <= '0;
            hold_q      <= 1'b0;
            hold_src_q  <= SRC_NONE;
            hold_chan_q <= '0;
            hold_id_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pend_q      <= pend_d;
            hold_q      <= result_valid & ~xif_result.result_ready;
            // A stalled incoming empty result has just been inserted into the pending set
            hold_src_q  <= (sel_src == SRC_EMPTY) ? SRC_PEND : sel_src;
            hold_chan_q <= sel_chan;
            hold_id_q   <= sel_id;
        end
    end

`ifdef VPROC_RESULT_STATS_EN
    logic [CHAN_CNT:0][31:0] stat_q;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            stat_q <= '0;
        end else if (accept) begin
            if (sel_src == SRC_CHAN) begin
                stat_q[sel_chan] <= stat_q[sel_chan] + 32'd1;
            end else begin
                stat_q[CHAN_CNT] <= stat_q[CHAN_CNT] + 32'd1;
            end
        end
    end

    assign stat_cnt_o = stat_q;
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vproc_result_arb.sv
// Directed bench for vproc_result_arb: one fixed-priority and one round-robin instance.
module tb_vproc_result_arb;
    import vproc_result_pkg::*;

    localparam int unsigned IDW = 3;
    localparam int unsigned CC  = 3;
    localparam int unsigned RW  = IDW + RES_FIELDS_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   f_ev, r_ev;
    logic [IDW-1:0]         f_eid, r_eid;
    logic [CC-1:0]          f_cv, f_cr, r_cv, r_cr;
    logic [CC-1:0][RW-1:0]  f_res, r_res;
    logic [CC:0][31:0]      f_stat, r_stat;

    xif_result_if #(.X_ID_WIDTH(IDW)) f_xif ();
    xif_result_if #(.X_ID_WIDTH(IDW)) r_xif ();

    vproc_result_arb #(
        .XIF_ID_W(IDW), .CHAN_CNT(CC), .CHAN_BUF_DEPTH(2), .ARB_MODE(ARB_FIXED),
        .DONT_CARE_ZERO(1'b0)
    ) u_fix (
        .clk_i(clk), .async_rst_ni(rst_n), .empty_valid_i(f_ev), .empty_id_i(f_eid),
        .chan_valid_i(f_cv), .chan_ready_o(f_cr), .chan_res_i(f_res), .stat_cnt_o(f_stat),
        .xif_result(f_xif)
    );

    vproc_result_arb #(
        .XIF_ID_W(IDW), .CHAN_CNT(CC), .CHAN_BUF_DEPTH(2), .ARB_MODE(ARB_RR),
        .DONT_CARE_ZERO(1'b0)
    ) u_rr (
        .clk_i(clk), .async_rst_ni(rst_n), .empty_valid_i(r_ev), .empty_id_i(r_eid),
        .chan_valid_i(r_cv), .chan_ready_o(r_cr), .chan_res_i(r_res), .stat_cnt_o(r_stat),
        .xif_result(r_xif)
    );

    int total  = 0;
    int passed = 0;

    function automatic logic [RW-1:0] mk(input logic [IDW-1:0] id, input logic [31:0] data);
        return {id, data[4:0], 1'b1, data, 1'b0, 6'd0};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (f_xif.result_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", f_xif.result_valid);
        else passed++;
        total++;
        if (f_cr !== 3'b111) $display("FAIL rst_ready: got %b want 111", f_cr);
        else passed++;
        total++;
        if (f_stat !== '0) $display("FAIL rst_stat: got %h want 0", f_stat);
        else passed++;
        total++;
        if (r_xif.result_valid !== 1'b0) $display("FAIL rst_rr_valid: got %b want 0", r_xif.result_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        f_xif.result_ready = 1'b0;
        f_cv = 3'b010;
        f_res[1] = mk(3'd1, 32'h11);
        #1;
        total++;
        if (f_xif.result_valid !== 1'b1 || f_xif.result.id !== 3'd1)
            $display("FAIL bp_lat0: got v=%b id=%0d want v=1 id=1", f_xif.result_valid, f_xif.result.id);
        else passed++;
        @(negedge clk);
        f_res[1] = mk(3'd2, 32'h22);
        #1;
        total++;
        if (f_cr[1] !== 1'b1 || f_xif.result.data !== 32'h11)
            $display("FAIL bp_second: got rdy=%b data=%h want 1 11", f_cr[1], f_xif.result.data);
        else passed++;
        @(negedge clk);
        f_res[1] = mk(3'd3, 32'h33);
        #1;
        total++;
        if (f_cr[1] !== 1'b0) $display("FAIL bp_full: got %b want 0", f_cr[1]);
        else passed++;
        @(negedge clk);
        f_cv = '0;
        f_xif.result_ready = 1'b1;
        #1;
        total++;
        if (f_xif.result.id !== 3'd1 || f_xif.result.data !== 32'h11)
            $display("FAIL bp_out0: got id=%0d data=%h want 1 11", f_xif.result.id, f_xif.result.data);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (f_xif.result_valid !== 1'b1 || f_xif.result.id !== 3'd2 || f_xif.result.data !== 32'h22)
            $display("FAIL bp_out1: got v=%b id=%0d data=%h want 1 2 22",
                     f_xif.result_valid, f_xif.result.id, f_xif.result.data);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (f_xif.result_valid !== 1'b0 || f_cr !== 3'b111)
            $display("FAIL bp_drained: got v=%b rdy=%b want 0 111", f_xif.result_valid, f_cr);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit drained;
        logic [IDW-1:0] exp_id [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0};
        logic           rdy    [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        r_cv = 3'b111;
        for (int c = 0; c < int'(CC); c++) r_res[c] = mk(IDW'(c), 32'hC0 + 32'(c));
        for (int i = 0; i < 6; i++) begin
            r_xif.result_ready = rdy[i];
            #1;
            total++;
            if (r_xif.result_valid !== 1'b1 || r_xif.result.id !== exp_id[i] ||
                r_xif.result.data !== 32'hC0 + 32'(exp_id[i]))
                $display("FAIL rr_grant%0d: got v=%b id=%0d data=%h want id=%0d", i,
                         r_xif.result_valid, r_xif.result.id, r_xif.result.data, exp_id[i]);
            else passed++;
            if (i >= 1 && i <= 3) begin
                total++;
                if (u_rr.rr_ptr_q !== 2'd1) $display("FAIL rr_ptr%0d: got %0d want 1", i, u_rr.rr_ptr_q);
                else passed++;
            end
            @(negedge clk);
        end
        r_cv = '0;
        drained = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!r_xif.result_valid) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!drained) $display("FAIL rr_drain: got still valid want idle within 20 cycles");
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_empty_order();
        logic [IDW-1:0] exp_id   [6] = '{3'd7, 3'd7, 3'd7, 3'd6, 3'd2, 3'd5};
        logic [31:0]    exp_data [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'h0, 32'h0};
        f_xif.result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            f_cv  = (i == 0) ? 3'b101 : (i < 3) ? 3'b001 : 3'b000;
            f_res[0] = mk(3'd7, 32'hA0 + 32'(i));
            f_res[2] = mk(3'd6, 32'hB0);
            f_ev  = (i < 2);
            f_eid = (i == 0) ? 3'd5 : 3'd2;
            #1;
            total++;
            if (f_xif.result_valid !== 1'b1 || f_xif.result.id !== exp_id[i] ||
                f_xif.result.data !== exp_data[i])
                $display("FAIL order%0d: got v=%b id=%0d data=%h want id=%0d data=%h", i,
                         f_xif.result_valid, f_xif.result.id, f_xif.result.data,
                         exp_id[i], exp_data[i]);
            else passed++;
            if (i >= 4) begin
                total++;
                if (f_xif.result.we !== 1'b0 || f_xif.result.rd !== 5'd0)
                    $display("FAIL order_zero%0d: got we=%b rd=%0d want 0 0", i,
                             f_xif.result.we, f_xif.result.rd);
                else passed++;
            end
            @(negedge clk);
        end
        f_ev = 1'b0;
        #1;
        total++;
        if (f_xif.result_valid !== 1'b0) $display("FAIL order_idle: got %b want 0", f_xif.result_valid);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_same_cycle_empty();
        f_xif.result_ready = 1'b1;
        f_ev  = 1'b1;
        f_eid = 3'd4;
        #1;
        total++;
        if (f_xif.result_valid !== 1'b1 || f_xif.result.id !== 3'd4 || f_xif.result.data !== '0)
            $display("FAIL same_out: got v=%b id=%0d data=%h want 1 4 0",
                     f_xif.result_valid, f_xif.result.id, f_xif.result.data);
        else passed++;
        @(negedge clk);
        f_ev = 1'b0;
        #1;
        total++;
        if (u_fix.pend_q !== 8'h00 || f_xif.result_valid !== 1'b0)
            $display("FAIL same_set: got set=%h v=%b want 00 0", u_fix.pend_q, f_xif.result_valid);
        else passed++;
        @(negedge clk);
        f_xif.result_ready = 1'b0;
        f_ev = 1'b1;
        #1;
        total++;
        if (f_xif.result.id !== 3'd4) $display("FAIL hold_c0: got id=%0d want 4", f_xif.result.id);
        else passed++;
        @(negedge clk);
        f_ev = 1'b0;
        #1;
        total++;
        if (f_xif.result_valid !== 1'b1 || f_xif.result.id !== 3'd4 || u_fix.pend_q !== 8'h10)
            $display("FAIL hold_c1: got v=%b id=%0d set=%h want 1 4 10",
                     f_xif.result_valid, f_xif.result.id, u_fix.pend_q);
        else passed++;
        @(negedge clk);
        f_xif.result_ready = 1'b1;
        #1;
        total++;
        if (f_xif.result.id !== 3'd4) $display("FAIL hold_c2: got id=%0d want 4", f_xif.result.id);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (u_fix.pend_q !== 8'h00 || f_xif.result_valid !== 1'b0)
            $display("FAIL hold_clear: got set=%h v=%b want 00 0", u_fix.pend_q, f_xif.result_valid);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        f_xif.result_ready = 1'b0;
        f_cv = 3'b100;
        f_res[2] = mk(3'd3, 32'h55);
        @(negedge clk);
        @(negedge clk);
        f_cv = '0;
        #1;
        total++;
        if (f_cr[2] !== 1'b0 || f_xif.result_valid !== 1'b1)
            $display("FAIL rmid_pre: got rdy=%b v=%b want 0 1", f_cr[2], f_xif.result_valid);
        else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (f_xif.result_valid !== 1'b0 || f_cr !== 3'b111)
            $display("FAIL rmid_drop: got v=%b rdy=%b want 0 111", f_xif.result_valid, f_cr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        f_xif.result_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (f_xif.result_valid !== 1'b0) $display("FAIL rmid_empty: got v=%b want 0", f_xif.result_valid);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_stats();
        logic [31:0] exp_c2, exp_e;
`ifdef VPROC_RESULT_STATS_EN
        exp_c2 = 32'd10;
        exp_e  = 32'd3;
`else
        exp_c2 = 32'd0;
        exp_e  = 32'd0;
`endif
        f_xif.result_ready = 1'b1;
        f_cv = 3'b100;
        for (int i = 0; i < 10; i++) begin
            f_res[2] = mk(3'd1, 32'(i));
            @(negedge clk);
        end
        f_cv = '0;
        for (int i = 0; i < 3; i++) begin
            f_ev  = 1'b1;
            f_eid = IDW'(i + 1);
            @(negedge clk);
        end
        f_ev = 1'b0;
        #1;
        total++;
        if (f_stat[2] !== exp_c2) $display("FAIL stat_chan2: got %0d want %0d", f_stat[2], exp_c2);
        else passed++;
        total++;
        if (f_stat[3] !== exp_e) $display("FAIL stat_empty: got %0d want %0d", f_stat[3], exp_e);
        else passed++;
        total++;
        if (f_stat[0] !== 32'd0 || f_stat[1] !== 32'd0)
            $display("FAIL stat_other: got %0d %0d want 0 0", f_stat[0], f_stat[1]);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        f_ev = 1'b0; f_eid = '0; f_cv = '0; f_res = '0; f_xif.result_ready = 1'b0;
        r_ev = 1'b0; r_eid = '0; r_cv = '0; r_res = '0; r_xif.result_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_round_robin();
        test_empty_order();
        test_same_cycle_empty();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
